regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard_if.sv | 51 +++++
 rtl/regfile_scoreboard.sv | 119 +++++++++++
 tb/tb_regfile_scoreboard.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback handshake bundle for regfile_scoreboard.
// SCOREBOARD_STATS_EN adds the stall_cnt_o statistics output.
interface regfile_scoreboard_if;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned STAT_W = 32;

  logic              issue_valid_i;
  logic              issue_rd_wren_i;
  logic [ADDR_W-1:0] issue_rd_addr_i;
  logic [ADDR_W-1:0] rs1_addr_i;
  logic [ADDR_W-1:0] rs2_addr_i;
  logic              rs1_used_i;
  logic              rs2_used_i;
  logic              wb_wren_i;
  logic [ADDR_W-1:0] wb_rd_addr_i;
  logic              flush_i;
  logic              stall_o;
  logic [NUM_REGS-1:0] busy_o;
`ifdef SCOREBOARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_o;

  modport master (
    output issue_valid_i, issue_rd_wren_i, issue_rd_addr_i,
    output rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
    output wb_wren_i, wb_rd_addr_i, flush_i,
    input  stall_o, busy_o, stall_cnt_o
  );

  modport slave (
    input  issue_valid_i, issue_rd_wren_i, issue_rd_addr_i,
    input  rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
    input  wb_wren_i, wb_rd_addr_i, flush_i,
    output stall_o, busy_o, stall_cnt_o
  );
`else
  modport master (
    output issue_valid_i, issue_rd_wren_i, issue_rd_addr_i,
    output rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
    output wb_wren_i, wb_rd_addr_i, flush_i,
    input  stall_o, busy_o
  );

  modport slave (
    input  issue_valid_i, issue_rd_wren_i, issue_rd_addr_i,
    input  rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
    input  wb_wren_i, wb_rd_addr_i, flush_i,
    output stall_o, busy_o
  );
`endif
endinterface

// File: rtl/regfile_scoreboard.sv
// Register-file scoreboard: per-register pending-write counters with RAW/overflow stall.
// Optional SCOREBOARD_STATS_EN adds a saturating stall-cycle counter (stall_cnt_o).
module regfile_scoreboard #(
  parameter int unsigned CNT_W = 2
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  regfile_scoreboard_if.slave bus
);

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned STAT_W   = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic [NUM_REGS-1:0] busy;
  logic                rs1_haz;
  logic                rs2_haz;
  logic                rd_full;
  logic                stall;
  logic                accept;

  // A source is clear if unused, x0, idle, or its last pending write retires this cycle.
  function automatic logic src_hazard(
    input logic              used,
    input logic [ADDR_W-1:0] addr,
    input logic [CNT_W-1:0]  cnt,
    input logic              wb_wren,
    input logic [ADDR_W-1:0] wb_addr
  );
    logic bypass;
    bypass = wb_wren && (wb_addr == addr) && (cnt == CNT_ONE);
    return used && (addr != '0) && (cnt != '0) && !bypass;
  endfunction

  always_comb begin
    rs1_haz = src_hazard(bus.rs1_used_i, bus.rs1_addr_i, cnt_q[bus.rs1_addr_i],
                         bus.wb_wren_i, bus.wb_rd_addr_i);
    rs2_haz = src_hazard(bus.rs2_used_i, bus.rs2_addr_i, cnt_q[bus.rs2_addr_i],
                         bus.wb_wren_i, bus.wb_rd_addr_i);
    rd_full = bus.issue_rd_wren_i && (bus.issue_rd_addr_i != '0) &&
              (cnt_q[bus.issue_rd_addr_i] == CNT_MAX);
    stall   = bus.issue_valid_i && (rs1_haz || rs2_haz || rd_full);
    accept  = bus.issue_valid_i && !stall;
  end

  // Per-register increment/decrement requests; x0 never tracked, empty counters never decrement.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      inc_vec[i] = accept && bus.issue_rd_wren_i && (bus.issue_rd_addr_i == ADDR_W'(i));
      dec_vec[i] = bus.wb_wren_i && (bus.wb_rd_addr_i == ADDR_W'(i)) && (cnt_q[i] != '0);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    cnt_d[0] = '0;
    if (bus.flush_i) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        cnt_d[i] = '0;
      end
    end else begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end else if (dec_vec[i] && !inc_vec[i]) begin
          cnt_d[i] = cnt_q[i] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      busy[i] = (cnt_q[i] != '0);
    end
  end

  assign bus.stall_o = stall;
  assign bus.busy_o  = busy;

`ifdef SCOREBOARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q;

  // Saturating count of stalled cycles; flush does not clear it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + STAT_W'(1);
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed scoreboard bench for regfile_scoreboard with a small reference model.
// Define SCOREBOARD_STATS_EN to also check stall_cnt_o.
module tb_regfile_scoreboard;
  localparam int unsigned CNT_W = 2;
  localparam int CMAX = (1 << CNT_W) - 1;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_scoreboard_if bus ();
  regfile_scoreboard #(.CNT_W(CNT_W)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int          m_cnt [32];
  int unsigned m_stalls;
  int          checks = 0;
  int          errors = 0;
  exp_t        q[$];

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    b = '0;
    for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] != 0);
    return b;
  endfunction

  function automatic bit m_haz(bit used, int a, bit ww, int wr);
    if (!used || a == 0 || m_cnt[a] == 0) return 1'b0;
    return !(ww && wr == a && m_cnt[a] == 1);
  endfunction

  task automatic push(string tag, logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic check(logic [31:0] obs);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h expected nothing", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic drive(bit iv, bit rw, int rd, int r1, bit u1, int r2, bit u2,
                       bit ww, int wr, bit fl);
    bus.issue_valid_i   = iv;
    bus.issue_rd_wren_i = rw;
    bus.issue_rd_addr_i = 5'(rd);
    bus.rs1_addr_i      = 5'(r1);
    bus.rs1_used_i      = u1;
    bus.rs2_addr_i      = 5'(r2);
    bus.rs2_used_i      = u2;
    bus.wb_wren_i       = ww;
    bus.wb_rd_addr_i    = 5'(wr);
    bus.flush_i         = fl;
  endtask

  // One clock: check stall/busy before the edge, advance the model, check state after it.
  task automatic cycle(string tag, bit iv, bit rw, int rd, int r1, bit u1, int r2, bit u2,
                       bit ww, int wr, bit fl);
    bit exp_stall;
    bit acc;
    bit inc;
    bit dec;
    drive(iv, rw, rd, r1, u1, r2, u2, ww, wr, fl);
    exp_stall = iv && (m_haz(u1, r1, ww, wr) || m_haz(u2, r2, ww, wr) ||
                       (rw && rd != 0 && m_cnt[rd] == CMAX));
    acc = iv && !exp_stall;
    push({tag, "/stall"}, 32'(exp_stall));
    push({tag, "/busy_pre"}, m_busy());
    #1;
    check(32'(bus.stall_o));
    check(bus.busy_o);
    @(posedge clk);
    if (fl) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        inc = acc && rw && rd == i;
        dec = ww && wr == i && m_cnt[i] > 0;
        if (inc && !dec) m_cnt[i]++;
        else if (dec && !inc) m_cnt[i]--;
      end
    end
    if (exp_stall) m_stalls++;
    push({tag, "/busy_post"}, m_busy());
`ifdef SCOREBOARD_STATS_EN
    push({tag, "/stall_cnt"}, m_stalls);
`endif
    #1;
    check(bus.busy_o);
`ifdef SCOREBOARD_STATS_EN
    check(bus.stall_cnt_o);
`endif
  endtask

  task automatic iss(string tag, int rd);
    cycle(tag, 1, 1, rd, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wb(string tag, int wr);
    cycle(tag, 0, 0, 0, 0, 0, 0, 0, 1, wr, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_stalls = 0;

    // Inputs active during reset must not stall or mark anything busy.
    drive(1, 1, 5, 5, 1, 6, 1, 1, 5, 0);
    push("rst/stall", 32'd0);
    push("rst/busy", 32'd0);
    #2;
    check(32'(bus.stall_o));
    check(bus.busy_o);
    @(posedge clk);
    #1;
    push("rst/busy_edge", 32'd0);
    check(bus.busy_o);
`ifdef SCOREBOARD_STATS_EN
    push("rst/stall_cnt", 32'd0);
    check(bus.stall_cnt_o);
`endif
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // RAW on rs1, then same-cycle writeback bypass on rs2.
    iss("iss_rd5", 5);
    cycle("raw_rs1", 1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    cycle("bypass_rs2", 1, 0, 0, 0, 0, 5, 1, 1, 5, 0);

    // x0 never tracked.
    for (int k = 0; k < 3; k++) iss("iss_rd0", 0);
    cycle("read_r0", 1, 0, 0, 0, 1, 0, 1, 0, 0, 0);

    // Counter saturation, simultaneous inc/dec, no underflow.
    for (int k = 0; k < 3; k++) iss("iss_rd7", 7);
    iss("full_rd7", 7);
    wb("wb_rd7_a", 7);
    cycle("incdec_rd7", 1, 1, 7, 0, 0, 0, 0, 1, 7, 0);
    iss("refill_rd7", 7);
    iss("full_rd7_b", 7);
    for (int k = 0; k < 3; k++) wb("drain_rd7", 7);
    wb("wb_empty_rd7", 7);
    iss("after_underflow_rd7", 7);
    wb("wb_rd7_b", 7);

    // Unused source ignored; a different writeback gives no bypass; no bypass at cnt=2.
    iss("iss_rd9", 9);
    cycle("rs2_unused", 1, 0, 0, 0, 0, 9, 0, 0, 0, 0);
    cycle("wb_other", 1, 0, 0, 9, 1, 0, 0, 1, 10, 0);
    iss("iss_rd9_b", 9);
    cycle("no_bypass_cnt2", 1, 0, 0, 9, 1, 0, 0, 1, 9, 0);

    // Flush: stall still reported while flushing, and flush beats a same-cycle issue.
    iss("iss_rd3", 3);
    iss("iss_rd3", 3);
    cycle("flush_stall", 1, 0, 0, 9, 1, 0, 0, 0, 0, 1);
    iss("iss_rd3_b", 3);
    iss("iss_rd3_b", 3);
    iss("iss_rd9_c", 9);
    cycle("flush_iss_rd3", 1, 1, 3, 0, 0, 0, 0, 0, 0, 1);

    // Reset asserted mid-stall.
    iss("iss_rd4", 4);
    drive(1, 0, 0, 4, 1, 0, 0, 0, 0, 0);
    push("midrst/stall_pre", 32'd1);
    #1;
    check(32'(bus.stall_o));
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_stalls = 0;
    push("midrst/stall", 32'd0);
    push("midrst/busy", 32'd0);
    #1;
    check(32'(bus.stall_o));
    check(bus.busy_o);
`ifdef SCOREBOARD_STATS_EN
    push("midrst/stall_cnt", 32'd0);
    check(bus.stall_cnt_o);
`endif
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    iss("post_rst_rd4", 4);

    // Four stalled cycles, then flush.
    for (int k = 0; k < 4; k++) cycle("stall_rd4", 1, 0, 0, 4, 1, 0, 0, 0, 0, 0);
    cycle("flush_stats", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
`ifdef SCOREBOARD_STATS_EN
    push("stats/after_flush", 32'd4);
    check(bus.stall_cnt_o);
`endif
    cycle("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    if (q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
